// File: rtl/map_update_arbiter.sv
// map_update_arbiter: tile-map write port owner; init sweep, then vblank-gated round-robin A/B updates.
module map_update_arbiter #(
  parameter int MAP_W = 13,
  parameter int MAP_H = 13,
  parameter int TYPE_BITS = 3,
  parameter logic [TYPE_BITS-1:0] INIT_TYPE = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 vblank_i,
  input  logic                 a_valid_i,
  input  logic [3:0]           a_x_i,
  input  logic [3:0]           a_y_i,
  input  logic [TYPE_BITS-1:0] a_type_i,
  output logic                 a_ready_o,
  input  logic                 b_valid_i,
  input  logic [3:0]           b_x_i,
  input  logic [3:0]           b_y_i,
  input  logic [TYPE_BITS-1:0] b_type_i,
  output logic                 b_ready_o,
  output logic                 wr_en_o,
  output logic [3:0]           wr_x_o,
  output logic [3:0]           wr_y_o,
  output logic [TYPE_BITS-1:0] wr_type_o,
  output logic                 busy_o,
  output logic [7:0]           drop_cnt_o
);
  typedef enum logic {INIT, RUN} state_e;
  localparam logic [3:0] XL = 4'(MAP_W - 1);
  localparam logic [3:0] YL = 4'(MAP_H - 1);
  state_e state_q, state_d;
  logic [3:0] x_q, x_d, y_q, y_d, wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [TYPE_BITS-1:0] wr_type_q, wr_type_d;
  logic wr_en_q, wr_en_d, busy_q, busy_d, last_b_q, last_b_d;
  logic [7:0] drop_q, drop_d;
  logic run, a_rdy, b_rdy, tx, in_range;
  logic [3:0] tx_x, tx_y;
  logic [TYPE_BITS-1:0] tx_type;
  // busy_q lags the state by one cycle so no grant overlaps the final sweep write
  always_comb begin
    run = state_q == RUN && !busy_q;
    a_rdy = run && vblank_i && a_valid_i && (!b_valid_i || last_b_q);
    b_rdy = run && vblank_i && b_valid_i && (!a_valid_i || !last_b_q);
    tx = a_rdy || b_rdy;
    tx_x = b_rdy ? b_x_i : a_x_i;
    tx_y = b_rdy ? b_y_i : a_y_i;
    tx_type = b_rdy ? b_type_i : a_type_i;
    in_range = tx_x <= XL && tx_y <= YL;
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    wr_en_d = 1'b0;
    wr_x_d = wr_x_q;
    wr_y_d = wr_y_q;
    wr_type_d = wr_type_q;
    drop_d = drop_q;
    last_b_d = last_b_q;
    busy_d = state_q == INIT;
    if (state_q == INIT) begin
      wr_en_d = 1'b1;
      wr_x_d = x_q;
      wr_y_d = y_q;
      wr_type_d = INIT_TYPE;
      x_d = x_q == XL ? 4'd0 : x_q + 4'd1;
      y_d = x_q == XL ? y_q + 4'd1 : y_q;
      state_d = (x_q == XL && y_q == YL) ? RUN : INIT;
    end else if (tx) begin
      last_b_d = b_rdy;
      wr_en_d = in_range;
      wr_x_d = in_range ? tx_x : wr_x_q;
      wr_y_d = in_range ? tx_y : wr_y_q;
      wr_type_d = in_range ? tx_type : wr_type_q;
      drop_d = in_range ? drop_q : drop_q + {7'd0, drop_q != 8'hff};
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      x_q <= '0;
      y_q <= '0;
      wr_en_q <= 1'b0;
      wr_x_q <= '0;
      wr_y_q <= '0;
      wr_type_q <= '0;
      busy_q <= 1'b1;
      drop_q <= '0;
      last_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      wr_en_q <= wr_en_d;
      wr_x_q <= wr_x_d;
      wr_y_q <= wr_y_d;
      wr_type_q <= wr_type_d;
      busy_q <= busy_d;
      drop_q <= drop_d;
      last_b_q <= last_b_d;
    end
  end
  assign a_ready_o = a_rdy;
  assign b_ready_o = b_rdy;
  assign wr_en_o = wr_en_q;
  assign wr_x_o = wr_x_q;
  assign wr_y_o = wr_y_q;
  assign wr_type_o = wr_type_q;
  assign busy_o = busy_q;
  assign drop_cnt_o = drop_q;
endmodule
